// File: rtl/table_stream_reader.sv
// Streams a ROWS x COLS register table out in row-major order over a valid/ready port.
// Optional running checksum on SUM is enabled by defining TABLE_STREAM_READER_SUM_EN.
module table_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WR_EN,
  input  logic [$clog2(ROWS)-1:0]  WR_ROW,
  input  logic [$clog2(COLS)-1:0]  WR_COL,
  input  logic [WIDTH-1:0]         WR_DATA,
  input  logic                     START,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WIDTH-1:0]         OUT_DATA,
  output logic [$clog2(ROWS)-1:0]  OUT_ROW,
  output logic [$clog2(COLS)-1:0]  OUT_COL,
  output logic                     OUT_LAST,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [WIDTH+3:0]         SUM
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned SW = WIDTH + 4;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tbl_q [ROWS][COLS];
  logic [WIDTH-1:0] tbl_d [ROWS][COLS];
  logic             handshake;

  assign handshake = valid_q & OUT_READY;

  // Next state, table writes and the registered view of the cursor element
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    tbl_d   = tbl_q;
    case (state_q)
      S_IDLE: begin
        if (WR_EN) tbl_d[WR_ROW][WR_COL] = WR_DATA;
        if (START) begin
          state_d = S_STREAM;
          row_d   = '0;
          col_d   = '0;
          // Read through tbl_d so a same-cycle write to (0,0) is what streams first
          data_d  = tbl_d[0][0];
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            data_d = tbl_q[row_d][col_d];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_STREAM);
    busy_d  = (state_d == S_STREAM);
    done_d  = (state_d == S_DONE);
    last_d  = (state_d == S_STREAM) && (row_d == ROW_MAX) && (col_d == COL_MAX);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          tbl_q[r][c] <= WIDTH'(r * int'(COLS) + c);
        end
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tbl_q   <= tbl_d;
    end
  end

`ifdef TABLE_STREAM_READER_SUM_EN
  logic [SW-1:0] sum_q, sum_d;

  // Checksum clears on an accepted START and otherwise holds between handshakes
  always_comb begin
    sum_d = sum_q;
    if ((state_q == S_IDLE) && START) begin
      sum_d = '0;
    end else if (handshake) begin
      sum_d = sum_q + SW'(data_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign SUM = sum_q;
`else
  assign SUM = '0;
`endif

  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign OUT_ROW   = row_q;
  assign OUT_COL   = col_q;
  assign OUT_LAST  = last_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_table_stream_reader.sv
// Directed bench for table_stream_reader: a vector table for the basic stream plus
// hand-written sequences for writes, stalls, ignored inputs and mid-stream reset.
module tb_table_stream_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       wr_row;
  logic [1:0]       wr_col;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [WIDTH+3:0] sum;

  always #5 clk = ~clk;

  table_stream_reader #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .WR_EN     (wr_en),
    .WR_ROW    (wr_row),
    .WR_COL    (wr_col),
    .WR_DATA   (wr_data),
    .START     (start),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OUT_ROW   (out_row),
    .OUT_COL   (out_col),
    .OUT_LAST  (out_last),
    .BUSY      (busy),
    .DONE      (done),
    .SUM       (sum)
  );

  typedef struct {
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [1:0] wr_col;
    logic [7:0] wr_data;
    logic       start;
    logic       ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_row;
    logic [1:0] e_col;
    logic       e_last;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl [16];
  vec_t       vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sum_exp();
    int s;
    s = 0;
`ifdef TABLE_STREAM_READER_SUM_EN
    for (int k = 0; k < 16; k++) s += int'(mdl[k]);
    s = s % 4096;
`endif
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mdl[k] = 8'(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic r, input logic we, input logic [1:0] wrr,
                              input logic [1:0] wrc, input logic [7:0] wd, input logic st,
                              input logic rdy, input logic ev, input logic [7:0] ed,
                              input logic [1:0] er, input logic [1:0] ec, input logic el,
                              input logic eb, input logic edn);
    vec_t v;
    v.rst_n = r;  v.wr_en = we; v.wr_row = wrr; v.wr_col = wrc; v.wr_data = wd;
    v.start = st; v.ready = rdy; v.e_valid = ev; v.e_data = ed; v.e_row = er;
    v.e_col = ec; v.e_last = el; v.e_busy = eb; v.e_done = edn;
    return v;
  endfunction

  // Checks elements first..15 with OUT_READY already high, then the DONE cycle and return to IDLE
  task automatic expect_stream(input string tag, input int first);
    for (int i = first; i < 16; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_data"}, 32'(out_data), 32'(mdl[i]));
      chk({tag, "_row"}, 32'(out_row), i / 4);
      chk({tag, "_col"}, 32'(out_col), i % 4);
      chk({tag, "_last"}, 32'(out_last), (i == 15) ? 1 : 0);
      chk({tag, "_busy"}, 32'(busy), 1);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_valid"}, 32'(out_valid), 0);
    chk({tag, "_done_busy"}, 32'(busy), 0);
    chk({tag, "_sum"}, 32'(sum), 32'(sum_exp()));
    tick();
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; out_ready = 1'b0;
    model_reset();

    // Basic stream from reset contents: index == value
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 15; i++) begin
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 8'(i + 1), 2'((i + 1) / 4), 2'((i + 1) % 4),
                        (i == 14) ? 1'b1 : 1'b0, 1, 0));
    end
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    foreach (vecs[n]) begin
      rst_n = vecs[n].rst_n; wr_en = vecs[n].wr_en; wr_row = vecs[n].wr_row;
      wr_col = vecs[n].wr_col; wr_data = vecs[n].wr_data; start = vecs[n].start;
      out_ready = vecs[n].ready;
      tick();
      chk($sformatf("vec%0d_valid", n), 32'(out_valid), 32'(vecs[n].e_valid));
      chk($sformatf("vec%0d_last", n), 32'(out_last), 32'(vecs[n].e_last));
      chk($sformatf("vec%0d_busy", n), 32'(busy), 32'(vecs[n].e_busy));
      chk($sformatf("vec%0d_done", n), 32'(done), 32'(vecs[n].e_done));
      if (vecs[n].e_valid || !vecs[n].rst_n) begin
        chk($sformatf("vec%0d_data", n), 32'(out_data), 32'(vecs[n].e_data));
        chk($sformatf("vec%0d_row", n), 32'(out_row), 32'(vecs[n].e_row));
        chk($sformatf("vec%0d_col", n), 32'(out_col), 32'(vecs[n].e_col));
      end
      if (!vecs[n].rst_n) chk($sformatf("vec%0d_sum", n), 32'(sum), 0);
    end
    chk("basic_sum", 32'(sum), 32'(sum_exp()));
    start = 1'b0;

    // IDLE write of 200 at (1,2) shows up as the 7th element
    wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd2; wr_data = 8'd200;
    tick();
    wr_en = 1'b0;
    mdl[6] = 8'd200;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    expect_stream("write", 0);

    // Stall three cycles on element (0,2)
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 2);
      chk("stall_row", 32'(out_row), 0);
      chk("stall_col", 32'(out_col), 2);
    end
    out_ready = 1'b1;
    tick();
    expect_stream("stall", 3);

    // Write and START together, then both held high during the stream
    do_reset();
    wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd9;
    start = 1'b1; out_ready = 1'b1;
    tick();
    mdl[0] = 8'd9;
    wr_row = 2'd2; wr_col = 2'd1; wr_data = 8'd77;
    expect_stream("same", 0);
    wr_en = 1'b0; start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_stream("same2", 0);

    // Reset after five handshakes aborts the stream and restores the table
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_pre_data", 32'(out_data), 5);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_data", 32'(out_data), 0);
    chk("abort_row", 32'(out_row), 0);
    chk("abort_col", 32'(out_col), 0);
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("abort_idle_done", 32'(done), 0);
    chk("abort_idle_valid", 32'(out_valid), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_stream("abort", 0);

    // START on the DONE cycle is ignored; the next IDLE START restarts with SUM cleared
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("donestart_done", 32'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("donestart_idle_valid", 32'(out_valid), 0);
    chk("donestart_idle_busy", 32'(busy), 0);
    tick();
    chk("donestart_ignored_valid", 32'(out_valid), 0);
    chk("donestart_ignored_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_sum", 32'(sum), 0);
    expect_stream("restart", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
